pw_multi_pattern_matcher: RTL
=============================

Name: pw_multi_pattern_matcher

Overview:
Sliding-window byte pattern matcher for the front-end data stream. It runs pCHANNELS independent pattern/mask slots, and each slot has its own programmable length. Matching uses a history shift register, so overlapping and self-similar patterns are detected correctly. The block adds one-shot/continuous arming, a saturating match counter, sticky status and first-hit reporting, and sits between the register block and the capture/trigger blocks.

Parameters:
pPATTERN_BYTES, 8, maximum pattern length in bytes (history depth); 1..64.
pCHANNELS, 2, number of independent pattern slots; 1..8.
pCOUNT_WIDTH, 16, width of the saturating match counter.

Ports:
fe_clk  input  1  front-end clock; the only clock.
reset_n  input  1  asynchronous, active-low reset.
I_arm  input  1  level; enables matching.
I_oneshot  input  1  1 = disarm after the first match; 0 = continuous.
I_clear  input  1  pulse; clears sticky, count and first-channel.
I_channel_enable  input  pCHANNELS  per-slot enable.
I_pattern  input  pCHANNELS*pPATTERN_BYTES*8  slot c occupies bits [c*pPATTERN_BYTES*8 +: pPATTERN_BYTES*8]; byte 0 is matched against the oldest byte of the window.
I_mask  input  pCHANNELS*pPATTERN_BYTES*8  same layout; mask bit 1 = compare that bit.
I_pattern_bytes  input  pCHANNELS*8  slot length L.
I_fe_data  input  8  stream byte.
I_fe_data_valid  input  1  byte qualifier.
O_match  output  pCHANNELS  one-cycle per-slot match pulse.
O_match_any  output  1  OR of O_match.
O_match_sticky  output  1  set on any match; held until I_clear.
O_match_count  output  pCOUNT_WIDTH  number of match events (cycles with O_match_any=1), saturating.
O_first_channel  output  3  lowest-index slot of the first match since clear.
O_armed  output  1  high in state ARMED.

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE, history and fill counter = 0, and every output = 0.
- FSM states and transitions:
  - IDLE -> ARMED when I_arm=1; entering ARMED zeroes the fill counter.
  - ARMED -> IDLE when I_arm=0.
  - ARMED -> DONE on a match when I_oneshot=1.
  - DONE -> IDLE when I_arm=0. DONE ignores all data.
- Shifting: in ARMED with I_fe_data_valid=1, the new byte shifts into hist[0] and older bytes move up toward hist[pPATTERN_BYTES-1]. The fill counter increments and saturates at pPATTERN_BYTES. Outside ARMED, the history is frozen.
- Match condition for slot c, all of:
  - the slot is enabled;
  - 1 <= L <= pPATTERN_BYTES (L=0 or L>pPATTERN_BYTES means the slot never matches);
  - fill after the shift >= L;
  - for every i < L: (hist'[L-1-i] ^ pat[i]) & mask[i] == 0, where hist' is the history including the current byte.
- Latency: O_match[c] is registered and high exactly one cycle after the fe_clk edge that accepted the completing byte. A match fires on every qualifying byte, so overlapping matches are all reported.
- An all-zero mask matches any L bytes once the fill counter reaches L.
- Several slots may pulse in the same cycle. That cycle counts once in O_match_count, and O_first_channel takes the lowest index.
- O_match_count increments by 1 per match cycle and holds at 2^pCOUNT_WIDTH-1.
- O_first_channel is latched only while O_match_sticky=0.
- I_clear coincident with a match: the clear applies first, then the match. Result: count=1, sticky=1, first_channel = that slot.
- Pattern, mask and length changes take effect on the next byte; the history is retained.
- I_arm falling in the same cycle as a completing byte: the byte is still evaluated, because the state is sampled before the transition.
- Asserting reset_n mid-stream drops any partial window; no match pulse is emitted.

Test Plan:
- L=3, pattern 0xAA 0xAA 0xAB, mask all ones; stream AA AA AA AB -> one O_match[0] pulse 1 cycle after the AB byte; count=1 (the overlap case a counter-based matcher misses).
- Continuous mode, L=2, pattern 55 55, stream 55 55 55 55 -> three pulses on consecutive valid bytes; count=3; first_channel=0.
- Slot0 pattern 01 02, slot1 pattern 02 (L=1), both enabled; stream 01 02 -> O_match=2'b11 in one cycle; count=1; first_channel=0.
- Oneshot=1, stream with two matches -> one pulse; state DONE; toggle I_arm 0->1 and repeat the stream -> a second pulse; count=2.
- Mask byte 0x0F on slot0 L=1, pattern 0x03; bytes 0x13, 0xF3, 0x14 -> pulses on the first two only.
- Count saturation with pCOUNT_WIDTH=2: five matches -> count=3. I_clear coincident with a match -> count=1, sticky=1.

Source files
------------

// File: rtl/pw_multi_pattern_matcher.sv
// ----------------------------------------------------------------------------
// PwMultiPatternMatcher
//
// Purpose:
//   Sliding-window byte pattern matcher for the front-end data stream.
//   pCHANNELS independent pattern/mask slots each have their own length.
//   Every slot is compared against a shared history shift register, so
//   overlapping and self-similar patterns are always found. On top of the
//   matching the block provides:
//     - one-shot or continuous arming,
//     - a saturating match counter,
//     - a sticky match flag,
//     - reporting of the first slot that matched.
//
// Ports:
//   fe_clk            front-end clock (only clock)
//   reset_n           asynchronous active-low reset
//   I_arm             level, enables matching
//   I_oneshot         1 = disarm (DONE) after the first match
//   I_clear           pulse, clears sticky flag, counter and first channel
//   I_channel_enable  per-slot enable
//   I_pattern         slot c at [c*pPATTERN_BYTES*8 +: pPATTERN_BYTES*8];
//                     byte 0 is compared with the oldest byte of the window
//   I_mask            same layout as I_pattern, bit 1 = compare that bit
//   I_pattern_bytes   per-slot length L, 8 bits per slot
//   I_fe_data         stream byte
//   I_fe_data_valid   stream byte qualifier
//   O_match           registered one-cycle per-slot match pulse
//   O_match_any       OR of O_match
//   O_match_sticky    set on any match, held until I_clear
//   O_match_count     saturating count of match cycles
//   O_first_channel   lowest-index slot of the first match since clear
//   O_armed           high while in ARMED
// ----------------------------------------------------------------------------
module pw_multi_pattern_matcher #(
    parameter int pPATTERN_BYTES = 8,
    parameter int pCHANNELS      = 2,
    parameter int pCOUNT_WIDTH   = 16
) (
    input  logic                                  fe_clk,
    input  logic                                  reset_n,
    input  logic                                  I_arm,
    input  logic                                  I_oneshot,
    input  logic                                  I_clear,
    input  logic [pCHANNELS-1:0]                  I_channel_enable,
    input  logic [pCHANNELS*pPATTERN_BYTES*8-1:0] I_pattern,
    input  logic [pCHANNELS*pPATTERN_BYTES*8-1:0] I_mask,
    input  logic [pCHANNELS*8-1:0]                I_pattern_bytes,
    input  logic [7:0]                            I_fe_data,
    input  logic                                  I_fe_data_valid,
    output logic [pCHANNELS-1:0]                  O_match,
    output logic                                  O_match_any,
    output logic                                  O_match_sticky,
    output logic [pCOUNT_WIDTH-1:0]               O_match_count,
    output logic [2:0]                            O_first_channel,
    output logic                                  O_armed
);

    localparam int FILL_W = $clog2(pPATTERN_BYTES + 1);
    localparam int SLOT_W = pPATTERN_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                               r_state;
    state_t                               w_state_next;
    logic [pPATTERN_BYTES-1:0][7:0]       r_hist;
    logic [pPATTERN_BYTES-1:0][7:0]       w_hist_next;
    logic [FILL_W-1:0]                    r_fill;
    logic [FILL_W-1:0]                    w_fill_next;
    logic                                 w_shift;
    logic [pCHANNELS-1:0]                 w_hit;
    logic                                 w_hit_any;
    logic [2:0]                           w_hit_first;
    logic [pCHANNELS-1:0]                 r_match;
    logic                                 r_sticky;
    logic [pCOUNT_WIDTH-1:0]              r_count;
    logic [2:0]                           r_first;

    // History window as it will look after the current byte is accepted.
    // The match logic evaluates this view, so the completing byte is seen
    // in the same cycle it arrives. The fill level tells how many entries
    // of the window hold real stream bytes since arming.
    always_comb begin
        w_shift     = (r_state == ST_ARMED) && I_fe_data_valid;
        w_hist_next = r_hist;
        w_fill_next = r_fill;
        if (w_shift) begin
            for (int i = pPATTERN_BYTES - 1; i > 0; i--) begin
                w_hist_next[i] = r_hist[i-1];
            end
            w_hist_next[0] = I_fe_data;
            if (int'(r_fill) < pPATTERN_BYTES) begin
                w_fill_next = r_fill + 1'b1;
            end
        end
    end

    // Per-slot comparison. Pattern byte i lines up with window entry L-1-i,
    // so pattern byte 0 meets the oldest byte of an L-byte window.
    // Lengths outside 1..pPATTERN_BYTES disable the slot entirely.
    always_comb begin
        int  len;
        logic ok;
        w_hit = '0;
        for (int c = 0; c < pCHANNELS; c++) begin
            len = int'(I_pattern_bytes[c*8 +: 8]);
            ok  = w_shift && I_channel_enable[c] && (len >= 1) &&
                  (len <= pPATTERN_BYTES) && (int'(w_fill_next) >= len);
            for (int i = 0; i < pPATTERN_BYTES; i++) begin
                if ((i < len) && (len <= pPATTERN_BYTES)) begin
                    if (((w_hist_next[len-1-i] ^ I_pattern[c*SLOT_W + i*8 +: 8]) &
                         I_mask[c*SLOT_W + i*8 +: 8]) != 8'h00) begin
                        ok = 1'b0;
                    end
                end
            end
            w_hit[c] = ok;
        end
    end

    // The lowest-index hitting slot wins, so scan from the top down.
    always_comb begin
        w_hit_any   = |w_hit;
        w_hit_first = 3'd0;
        for (int c = pCHANNELS - 1; c >= 0; c--) begin
            if (w_hit[c]) begin
                w_hit_first = 3'(c);
            end
        end
    end

    // Next-state logic. The match is computed from the current state, so a
    // byte that arrives while I_arm falls is still evaluated.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (I_arm) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!I_arm) begin
                    w_state_next = ST_IDLE;
                end else if (w_hit_any && I_oneshot) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!I_arm) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, history and fill registers.
    // Entering ARMED restarts the fill level, so stale history bytes can
    // never complete a match. The history is only frozen, never wiped,
    // outside reset.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_hist  <= '0;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hist  <= w_hist_next;
            if ((r_state == ST_IDLE) && I_arm) begin
                r_fill <= '0;
            end else begin
                r_fill <= w_fill_next;
            end
        end
    end

    // Match pulse and status.
    // These update on the same edge that registers the pulse. A clear is
    // applied first, then a coincident match, so clear+match leaves
    // count=1 and sticky set.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_match  <= '0;
            r_sticky <= 1'b0;
            r_count  <= '0;
            r_first  <= 3'd0;
        end else begin
            r_match <= w_hit;
            if (I_clear) begin
                r_sticky <= 1'b0;
                r_count  <= '0;
                r_first  <= 3'd0;
            end
            if (w_hit_any) begin
                r_sticky <= 1'b1;
                if (I_clear || !r_sticky) begin
                    r_first <= w_hit_first;
                end
                if (I_clear) begin
                    r_count <= pCOUNT_WIDTH'(1);
                end else if (r_count != {pCOUNT_WIDTH{1'b1}}) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign O_match         = r_match;
    assign O_match_any     = |r_match;
    assign O_match_sticky  = r_sticky;
    assign O_match_count   = r_count;
    assign O_first_channel = r_first;
    assign O_armed         = (r_state == ST_ARMED);

endmodule
